// File: rtl/frame_to_uart_tx_if.sv
// frame_to_uart_tx_if
//   Bundles the frame-load side and the UART send/busy side of the frame
//   serializer.
//   master : frame source plus UART transmitter, which drive data_in, len_in,
//            load and busy.
//   slave  : the serializer itself, which drives data_out, send, ready, done
//            and ovr.
interface frame_to_uart_tx_if #(
   parameter int NBYTES = 51,
   parameter int LEN_W  = $clog2(NBYTES + 1)
);
   logic [8*NBYTES-1:0] data_in;
   logic [LEN_W-1:0]    len_in;
   logic                load;
   logic                busy;
   logic [7:0]          data_out;
   logic                send;
   logic                ready;
   logic                done;
   logic                ovr;

   modport master (
      output data_in, len_in, load, busy,
      input  data_out, send, ready, done, ovr
   );

   modport slave (
      input  data_in, len_in, load, busy,
      output data_out, send, ready, done, ovr
   );
endinterface

// File: rtl/frame_to_uart_tx.sv
// frame_to_uart_tx
//   Latches a frame word of up to NBYTES bytes and hands it to a UART
//   transmitter one byte at a time, using the send/busy handshake.
//   The frame length is set at run time. The byte order is chosen by a
//   parameter. An optional idle gap can be inserted between bytes. A timeout
//   covers a transmitter that never raises busy.
// Ports
//   clk        system clock; all logic runs on its rising edge
//   rst        synchronous reset, active-high
//   tx.slave   data_in/len_in/load: frame request
//              busy: transmitter busy
//              data_out/send: byte strobe to the transmitter
//              ready: IDLE, so a load will be accepted
//              done: end-of-frame pulse
//              ovr: pulse when a load arrives while a frame is in progress
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | no frame in progress; ready=1
// S_WAIT_FREE| byte pending; wait for the transmitter to report not busy
// S_SEND     | send strobe cycle; advance shift reg and byte count
// S_WAIT_ACK | wait for busy to rise, or for the ACK_TO timeout
// S_GAP      | idle spacing of GAP_CYC clocks before the next byte
module frame_to_uart_tx #(
   parameter int NBYTES    = 51,
   parameter int LEN_W     = $clog2(NBYTES + 1),
   parameter bit MSB_FIRST = 1'b1,
   parameter int GAP_CYC   = 0,
   parameter int ACK_TO    = 4
) (
   input logic               clk,
   input logic               rst,
   frame_to_uart_tx_if.slave tx
);

   localparam int W     = 8 * NBYTES;
   localparam int TMAX  = (ACK_TO > GAP_CYC) ? ACK_TO : GAP_CYC;
   localparam int TMR_W = (TMAX < 2) ? 1 : $clog2(TMAX);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_FREE,
      S_SEND,
      S_WAIT_ACK,
      S_GAP
   } state_t;

   state_t           state;
   logic [W-1:0]     shreg;
   logic [LEN_W-1:0] cnt;
   logic [TMR_W-1:0] tmr;
   logic [7:0]       cur_byte;
   logic [W-1:0]     shreg_nxt;

   // The byte to transmit is always at the outgoing end of the shift register.
   assign cur_byte  = MSB_FIRST ? shreg[W-1 -: 8] : shreg[7:0];
   assign shreg_nxt = MSB_FIRST ? (shreg << 8) : (shreg >> 8);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         shreg       <= '0;
         cnt         <= '0;
         tmr         <= '0;
         tx.data_out <= 8'h00;
         tx.send     <= 1'b0;
         tx.ready    <= 1'b1;
         tx.done     <= 1'b0;
         tx.ovr      <= 1'b0;
      end else begin
         tx.send <= 1'b0;
         tx.done <= 1'b0;
         tx.ovr  <= 1'b0;

         // A load that arrives mid-frame is dropped and flagged. This also
         // covers the edge that produces done, because the state is not
         // IDLE yet at that edge.
         if (tx.load && (state != S_IDLE)) begin
            tx.ovr <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (tx.load) begin
                  if (tx.len_in == '0) begin
                     tx.done <= 1'b1;
                  end else begin
                     shreg    <= tx.data_in;
                     cnt      <= (tx.len_in > LEN_W'(NBYTES)) ? LEN_W'(NBYTES) : tx.len_in;
                     state    <= S_WAIT_FREE;
                     tx.ready <= 1'b0;
                  end
               end
            end

            S_WAIT_FREE: begin
               if (!tx.busy) begin
                  state       <= S_SEND;
                  tx.send     <= 1'b1;
                  tx.data_out <= cur_byte;
               end
            end

            S_SEND: begin
               shreg <= shreg_nxt;
               cnt   <= cnt - LEN_W'(1);
               tmr   <= TMR_W'(ACK_TO - 1);
               state <= S_WAIT_ACK;
            end

            S_WAIT_ACK: begin
               // The byte counts as taken on busy or on timeout.
               if (tx.busy || (tmr == '0)) begin
                  if (cnt == '0) begin
                     state    <= S_IDLE;
                     tx.done  <= 1'b1;
                     tx.ready <= 1'b1;
                  end else if (GAP_CYC > 0) begin
                     state <= S_GAP;
                     tmr   <= TMR_W'(GAP_CYC - 1);
                  end else begin
                     state <= S_WAIT_FREE;
                  end
               end else begin
                  tmr <= tmr - TMR_W'(1);
               end
            end

            S_GAP: begin
               if (tmr == '0) begin
                  state <= S_WAIT_FREE;
               end else begin
                  tmr <= tmr - TMR_W'(1);
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
